// File: rtl/alu_pkg.sv
// Shared frame/status types and the CRC3 / error-parity helpers for the ALU
// serial response receiver.
package alu_pkg;

  typedef enum logic {DATA = 1'b0, CTL = 1'b1} packet_t;
  typedef enum logic {OK = 1'b0, ERROR = 1'b1} status_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  // Bits following the start bit: type, 8 payload, stop.
  localparam int FRAME_BITS = 10;

  // x^3+x+1, init 0, MSB first.
  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = msg[i] ^ crc[2];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  function automatic logic err_parity(input logic [6:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Serial frame receiver: start 0, type, 8 payload bits MSB first, stop 1.
// Hands one frame up per DONE cycle; a bad stop bit resyncs on a high line.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a start bit
// S_RX     | shifting type, payload and stop (count 0..9)
// S_DONE   | frame_valid high for one cycle; a new start bit is accepted here
// S_RESYNC | stop bit was 0, waiting for the line to return high
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sout,
  output logic       frame_valid,
  output packet_t    frame_type,
  output logic [7:0] frame_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_DONE, S_RESYNC} rx_state_t;

  rx_state_t  state_q;
  logic [3:0] cnt_q;
  logic [8:0] shift_q;
  logic       valid_q;
  packet_t    type_q;
  logic [7:0] data_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 9'd0;
      valid_q <= 1'b0;
      type_q  <= DATA;
      data_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sout) begin
            state_q <= S_RX;
            cnt_q   <= 4'd0;
          end
        end
        S_RX: begin
          if (cnt_q == 4'(FRAME_BITS - 1)) begin
            valid_q <= 1'b1;
            err_q   <= ~sout;
            type_q  <= packet_t'(shift_q[8]);
            data_q  <= shift_q[7:0];
            state_q <= S_DONE;
          end else begin
            shift_q <= {shift_q[7:0], sout};
            cnt_q   <= cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          if (err_q) begin
            state_q <= sout ? S_IDLE : S_RESYNC;
          end else if (!sout) begin
            state_q <= S_RX;
            cnt_q   <= 4'd0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          if (sout) state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign frame_valid = valid_q;
  assign frame_type  = type_q;
  assign frame_data  = data_q;
  assign frame_err   = err_q;

endmodule

// File: rtl/alu_rsp_rx.sv
// ALU response sequencer: assembles 4 DATA + CTL (OK) or a lone CTL (ERROR)
// and reports each completed or aborted response with a one-cycle pulse.
//
// state      | meaning
// WAIT_FIRST | no frame of a response seen yet; no timeout
// DATA1..3   | 1..3 DATA bytes collected
// WAIT_CTL   | 4 DATA bytes collected, expecting the OK CTL frame
// REPORT     | rsp_valid cycle, then back to WAIT_FIRST
module alu_rsp_rx
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        rsp_valid,
  output status_t     rsp_status,
  output logic [31:0] rsp_c,
  output logic [3:0]  rsp_flags,
  output logic [2:0]  rsp_err,
  output logic        rsp_chk_fail
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {WAIT_FIRST, DATA1, DATA2, DATA3, WAIT_CTL, REPORT} seq_state_t;

  logic       frame_valid;
  packet_t    frame_type;
  logic [7:0] frame_data;
  logic       frame_err;

  alu_frame_rx u_frame_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sout        (sout),
    .frame_valid (frame_valid),
    .frame_type  (frame_type),
    .frame_data  (frame_data),
    .frame_err   (frame_err)
  );

  seq_state_t    state_q;
  logic [31:0]   c_acc_q;
  logic          gap_q;
  logic [TW-1:0] timer_q;
  logic          valid_q;
  status_t       status_q;
  logic [31:0]   c_q;
  flags_t        flags_q;
  logic [2:0]    err_q;
  logic          chk_q;

  logic abort;
  logic done_ok;
  logic done_err;
  logic crc_bad;
  logic err_chk;

  assign crc_bad = crc3({c_acc_q, 1'b0, frame_data[6:3]}) != frame_data[2:0];
  assign err_chk = (frame_data[6:4] != frame_data[3:1]) ||
                   (frame_data[0] != err_parity(frame_data[7:1]));

  always_comb begin
    abort    = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    if (state_q != REPORT) begin
      if (frame_valid) begin
        if (frame_err) begin
          abort = 1'b1;
        end else begin
          case (state_q)
            WAIT_FIRST: if (frame_type == CTL) begin
              if (frame_data[7]) done_err = 1'b1;
              else               abort    = 1'b1;
            end
            WAIT_CTL: begin
              if (frame_type == DATA || frame_data[7]) abort   = 1'b1;
              else                                     done_ok = 1'b1;
            end
            default: if (frame_type == CTL) abort = 1'b1;
          endcase
        end
      end else if (gap_q && sout && timer_q == '0) begin
        abort = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_FIRST;
      c_acc_q  <= 32'd0;
      gap_q    <= 1'b0;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      status_q <= OK;
      c_q      <= 32'd0;
      flags_q  <= '0;
      err_q    <= 3'd0;
      chk_q    <= 1'b0;
    end else begin
      valid_q <= abort | done_ok | done_err;
      if (abort) begin
        status_q <= ERROR;
        chk_q    <= 1'b1;
        gap_q    <= 1'b0;
        state_q  <= REPORT;
      end else if (done_err) begin
        status_q <= ERROR;
        err_q    <= frame_data[6:4];
        chk_q    <= err_chk;
        state_q  <= REPORT;
      end else if (done_ok) begin
        status_q <= OK;
        c_q      <= c_acc_q;
        flags_q  <= flags_t'(frame_data[6:3]);
        chk_q    <= crc_bad;
        gap_q    <= 1'b0;
        state_q  <= REPORT;
      end else begin
        case (state_q)
          REPORT: begin
            state_q <= WAIT_FIRST;
            gap_q   <= 1'b0;
          end
          default: begin
            // Here a frame can only be a DATA byte in WAIT_FIRST..DATA3.
            if (frame_valid) begin
              c_acc_q <= {c_acc_q[23:0], frame_data};
              gap_q   <= sout;
              timer_q <= TIMER_LOAD;
              case (state_q)
                WAIT_FIRST: state_q <= DATA1;
                DATA1:      state_q <= DATA2;
                DATA2:      state_q <= DATA3;
                default:    state_q <= WAIT_CTL;
              endcase
            end else if (gap_q) begin
              if (!sout) gap_q   <= 1'b0;
              else       timer_q <= timer_q - TW'(1);
            end
          end
        endcase
      end
    end
  end

  assign rsp_valid    = valid_q;
  assign rsp_status   = status_q;
  assign rsp_c        = c_q;
  assign rsp_flags    = flags_q;
  assign rsp_err      = err_q;
  assign rsp_chk_fail = chk_q;

endmodule

// File: tb/tb_alu_rsp_rx.sv
// Randomized bench for alu_rsp_rx with a transaction-level scoreboard.
module tb_alu_rsp_rx;
  import alu_pkg::*;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sout = 1'b1;
  logic        rsp_valid;
  status_t     rsp_status;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic [2:0]  rsp_err;
  logic        rsp_chk_fail;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    status_t     status;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  err;
    logic        chk;
  } obs_t;

  typedef struct {
    logic        use_stat;
    status_t     status;
    logic        use_c;
    logic [31:0] c;
    logic [3:0]  flags;
    logic        use_err;
    logic [2:0]  err;
    logic        chk;
  } exp_t;

  obs_t act_q[$];
  exp_t exp_q[$];

  alu_rsp_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sout         (sout),
    .rsp_valid    (rsp_valid),
    .rsp_status   (rsp_status),
    .rsp_c        (rsp_c),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .rsp_chk_fail (rsp_chk_fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rsp_valid) act_q.push_back('{rsp_status, rsp_c, rsp_flags, rsp_err, rsp_chk_fail});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  // Remainder of ({C, 0, flags} * x^3) modulo x^3+x+1 by long division.
  function automatic logic [2:0] model_crc(input logic [31:0] c, input logic [3:0] f);
    longint unsigned m;
    m = {27'd0, c, 1'b0, f} << 3;
    for (int i = 39; i >= 3; i--)
      if (m[i]) m = m ^ (64'hB << (i - 3));
    return m[2:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_status"}, 32'(rsp_status), 32'(OK));
    check_eq({tag, "_c"}, rsp_c, 32'd0);
    check_eq({tag, "_flags"}, 32'(rsp_flags), 32'd0);
    check_eq({tag, "_err"}, 32'(rsp_err), 32'd0);
    check_eq({tag, "_chk"}, 32'(rsp_chk_fail), 32'd0);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sout = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input packet_t t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(logic'(t));
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic push_ok(input logic [31:0] c, input logic [3:0] f, input logic bad);
    exp_q.push_back('{1'b1, OK, 1'b1, c, f, 1'b0, 3'd0, bad});
  endtask

  task automatic push_abort(input logic use_stat);
    exp_q.push_back('{use_stat, ERROR, 1'b0, 32'd0, 4'd0, 1'b0, 3'd0, 1'b1});
  endtask

  task automatic send_ok(input logic [31:0] c, input logic [3:0] f,
                         input logic [2:0] crc_xor, input int max_gap);
    for (int k = 3; k >= 0; k--) begin
      send_frame(DATA, c[8*k +: 8], 1'b1);
      idle(int'($urandom_range(max_gap, 0)));
    end
    send_frame(CTL, {1'b0, f, model_crc(c, f) ^ crc_xor}, 1'b1);
    push_ok(c, f, crc_xor != 3'd0);
  endtask

  task automatic send_errf(input logic [2:0] e, input logic [2:0] copy_xor, input logic par_flip);
    logic [6:0] body;
    logic       p;
    body = {1'b1, e, e ^ copy_xor};
    p    = (($countones(body) % 2) == 1) ^ par_flip;
    send_frame(CTL, {body, p}, 1'b1);
    exp_q.push_back('{1'b1, ERROR, 1'b0, 32'd0, 4'd0, 1'b1, e, (copy_xor != 3'd0) || par_flip});
  endtask

  task automatic drain();
    obs_t a;
    exp_t x;
    for (int i = 0; i < 60 && act_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("pulse_count", act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      x = exp_q.pop_front();
      if (x.use_stat) check_eq("status", 32'(a.status), 32'(x.status));
      if (x.use_c) begin
        check_eq("rsp_c", a.c, x.c);
        check_eq("rsp_flags", 32'(a.flags), 32'(x.flags));
      end
      if (x.use_err) check_eq("rsp_err", 32'(a.err), 32'(x.err));
      check_eq("chk_fail", 32'(a.chk), 32'(x.chk));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  logic [31:0] c;
  logic [3:0]  f;
  int          kind;
  int          gap;

  initial begin
    rst_n = 1'b0;
    sout  = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // Minimal OK response with a known value.
    send_ok(32'h0000_0003, 4'h0, 3'b000, 0);
    drain();

    // Error frames: op error, then the same with the parity bit wrong.
    send_frame(CTL, 8'h93, 1'b1);
    exp_q.push_back('{1'b1, ERROR, 1'b0, 32'd0, 4'd0, 1'b1, 3'b001, 1'b0});
    drain();
    send_frame(CTL, 8'h92, 1'b1);
    exp_q.push_back('{1'b1, ERROR, 1'b0, 32'd0, 4'd0, 1'b1, 3'b001, 1'b1});
    drain();

    // Single inverted crc3 bit.
    send_ok($urandom, 4'($urandom_range(15, 0)), 3'b001 << $urandom_range(2, 0), 2);
    drain();

    // Stop bit 0 in the second DATA frame, then a clean response.
    send_frame(DATA, 8'hA5, 1'b1);
    idle(1);
    send_frame(DATA, 8'h5A, 1'b0);
    idle(2);
    push_abort(1'b0);
    send_ok($urandom, 4'($urandom_range(15, 0)), 3'b000, 1);
    drain();

    // CTL after 1..3 DATA frames.
    for (int n = 1; n <= 3; n++) begin
      for (int k = 0; k < n; k++) send_frame(DATA, 8'($urandom), 1'b1);
      send_frame(CTL, {1'b0, 7'($urandom)}, 1'b1);
      push_abort(1'b1);
      drain();
    end

    // Fifth DATA frame where CTL is expected.
    for (int k = 0; k < 5; k++) send_frame(DATA, 8'($urandom), 1'b1);
    push_abort(1'b1);
    drain();

    // Error-style CTL (leading 1) after four DATA frames.
    for (int k = 0; k < 4; k++) send_frame(DATA, 8'($urandom), 1'b1);
    send_frame(CTL, 8'h93, 1'b1);
    push_abort(1'b1);
    drain();

    // Gap of exactly TMO idle clocks is still accepted.
    c = $urandom;
    f = 4'($urandom_range(15, 0));
    send_frame(DATA, c[31:24], 1'b1);
    send_frame(DATA, c[23:16], 1'b1);
    idle(TMO);
    send_frame(DATA, c[15:8], 1'b1);
    send_frame(DATA, c[7:0], 1'b1);
    send_frame(CTL, {1'b0, f, model_crc(c, f)}, 1'b1);
    push_ok(c, f, 1'b0);
    drain();

    // One clock longer times out.
    send_frame(DATA, 8'h12, 1'b1);
    send_frame(DATA, 8'h34, 1'b1);
    idle(TMO + 1);
    push_abort(1'b0);
    drain();

    // Reset during the third DATA frame.
    send_frame(DATA, 8'hDE, 1'b1);
    send_frame(DATA, 8'hAD, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sout  = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    idle(2);
    drain();
    send_ok($urandom, 4'($urandom_range(15, 0)), 3'b000, 2);
    drain();

    // Back-to-back responses with no idle clock between them.
    send_ok($urandom, 4'($urandom_range(15, 0)), 3'b000, 0);
    send_errf(3'($urandom_range(7, 0)), 3'b000, 1'b0);
    send_ok($urandom, 4'($urandom_range(15, 0)), 3'b000, 0);
    drain();

    // Random mix of OK and ERROR responses with random gaps.
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(3, 0));
      gap  = int'($urandom_range(3, 0));
      if (kind != 0)
        send_ok($urandom, 4'($urandom_range(15, 0)),
                ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'b000, 3);
      else
        send_errf(3'($urandom_range(7, 0)),
                  ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'b000,
                  $urandom_range(3, 0) == 0);
      idle(gap);
      if (gap != 0) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_rsp_rx.md
ALU_RSP_RX -- requirements
Module: alu_rsp_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: maximum idle clocks allowed between frames inside one response.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  clock; all sampling on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sout  input  1  ALU serial response line; idle high; one bit per clk.
REQ-006 rsp_valid  output  1  one-cycle pulse when a response completes or aborts.
REQ-007 rsp_status  output  status_t  OK for a data response, ERROR for an error response.
REQ-008 rsp_c  output  32  result C; byte from the first DATA frame is C[31:24].
REQ-009 rsp_flags  output  4  {carry, overflow, zero, negative} from the OK CTL frame.
REQ-010 rsp_err  output  3  {err_data, err_crc, err_op} from the ERROR CTL frame.
REQ-011 rsp_chk_fail  output  1  CRC3/parity mismatch, duplicated-flag mismatch, framing, sequence or timeout fault.

Function
REQ-012 Frame format: start 0, type bit (packet_t: DATA=0, CTL=1), 8 payload bits MSB first, stop 1; 11 clocks per frame.
REQ-013 Frame receiver states: IDLE (sout=1), RX (10 bits counted 0..9 after the start bit), DONE (1 cycle, frame handed up); return to IDLE.
REQ-014 Response sequencer states: WAIT_FIRST, DATA1..DATA3, WAIT_CTL, REPORT.
REQ-015 OK response: 4 DATA frames then CTL payload {0, flags[3:0], crc3[2:0]}.
REQ-016 crc3: polynomial x^3+x+1, init 0, over the 37 bits {C[31:0], 1'b0, flags[3:0]}, MSB first.
REQ-017 ERROR response: a single CTL frame, received in WAIT_FIRST, payload {1, ed, ec, eo, ed, ec, eo, p}; p = even parity over the preceding 7 bits.
REQ-018 rsp_valid asserts in the cycle after DONE of the final frame; rsp_* hold until the next rsp_valid.
REQ-019 Stop bit sampled 0: abort, pulse rsp_valid with rsp_chk_fail=1, and resynchronise by waiting for sout=1 before IDLE.
REQ-020 CTL frame after 1-3 DATA frames, or DATA frame in WAIT_CTL: abort with rsp_chk_fail=1 and rsp_status=ERROR.
REQ-021 CTL frame with leading payload 1 in WAIT_CTL: sequence fault, abort as REQ-020.
REQ-022 Gap longer than TIMEOUT_CYCLES between frames after the first frame: abort with rsp_chk_fail=1; no timeout applies in WAIT_FIRST.
REQ-023 ERROR frame whose two flag copies differ: rsp_err takes the first copy and rsp_chk_fail=1.
REQ-024 A start bit in the cycle immediately after a stop bit SHALL be accepted; back-to-back responses SHALL be lossless.

Reset
REQ-025 On rst_n=0: both FSMs go idle, counters clear, rsp_valid=0, rsp_status=OK, rsp_c=0, rsp_flags=0, rsp_err=0, rsp_chk_fail=0.
REQ-026 Reset mid-frame SHALL discard the partial response without a rsp_valid pulse.

Structure
REQ-027 packet_t, status_t, a flags struct, a crc3 function and the error-frame parity function SHALL reside in the shared package alu_pkg.
REQ-028 The frame receiver SHALL be a sub-module alu_frame_rx (outputs: frame_valid, frame_type, frame_data[7:0], frame_err).

Verification
REQ-029 Bytes 00,00,00,03, then CTL {0, 0000, crc3} -> rsp_valid once, OK, rsp_c=0x00000003, rsp_flags=0, chk_fail=0.
REQ-030 CTL payload 0x93 (op error) -> rsp_valid, ERROR, rsp_err=3'b001, chk_fail=0; payload 0x92 -> chk_fail=1.
REQ-031 4 DATA frames with a correct CTL except one crc3 bit inverted -> OK, rsp_c intact, chk_fail=1.
REQ-032 Stop bit forced 0 in the second DATA frame -> abort pulse with chk_fail=1, then a clean response decodes correctly.
REQ-033 2 DATA frames, then 1001 idle clocks with TIMEOUT_CYCLES=1000 -> abort pulse with chk_fail=1.
REQ-034 rst_n pulsed low during the third DATA frame -> no rsp_valid, all outputs 0, and the next full response decodes.
